mmu_arbiter: RTL and testbench

- Shares the single MMU request port between two requesters: port 0 is the CPU core and port 1 is a DMA/debug master.
- Each requester issues single-cycle command pulses in the same style as the CPU-to-MMU interface.
- The arbiter captures each pulse, grants one transaction at a time to the MMU in round-robin order, and routes the read data, valid and error response back to the owning requester.
- A watchdog converts a lost MMU response into an error completion.

---
 rtl/mmu_arbiter.sv | 133 +++++++++++++
 tb/tb_mmu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: round-robin sharing of one MMU request port between two requesters, with response watchdog
module mmu_arbiter #(
  parameter int         TIMEOUT     = 255,
  parameter logic [3:0] ERR_TIMEOUT = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wrdata,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_cmd,
  input  logic        m0_valid,
  input  logic        m0_usermode,
  output logic [31:0] m0_rddata,
  output logic        m0_rdvalid,
  output logic [3:0]  m0_error,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wrdata,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_cmd,
  input  logic        m1_valid,
  input  logic        m1_usermode,
  output logic [31:0] m1_rddata,
  output logic        m1_rdvalid,
  output logic [3:0]  m1_error,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wrdata,
  output logic [1:0]  mmu_size,
  output logic [3:0]  mmu_cmd,
  output logic        mmu_validcmd,
  output logic        mmu_usermode,
  input  logic [31:0] mmu_rddata,
  input  logic        mmu_rddata_valid,
  input  logic [3:0]  mmu_error
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state;
  logic [1:0]  pend;
  logic        last_grant, owner, gnt, done;
  logic [15:0] watchdog;
  logic [31:0] h_addr [2];
  logic [31:0] h_wrdata [2];
  logic [1:0]  h_size [2];
  logic [3:0]  h_cmd [2];
  logic        h_user [2];
  logic [31:0] rsp_data;
  logic [3:0]  rsp_err;
  always_comb begin
    gnt      = &pend ? ~last_grant : pend[1];
    done     = mmu_rddata_valid || watchdog == 16'(TIMEOUT - 1);
    rsp_data = mmu_rddata_valid ? mmu_rddata : '0;
    rsp_err  = mmu_rddata_valid ? mmu_error : ERR_TIMEOUT;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      pend         <= '0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      watchdog     <= '0;
      m0_rdvalid   <= 1'b0;
      m0_rddata    <= '0;
      m0_error     <= '0;
      m1_rdvalid   <= 1'b0;
      m1_rddata    <= '0;
      m1_error     <= '0;
      mmu_validcmd <= 1'b0;
      mmu_addr     <= '0;
      mmu_wrdata   <= '0;
      mmu_size     <= '0;
      mmu_cmd      <= '0;
      mmu_usermode <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        h_addr[i]   <= '0;
        h_wrdata[i] <= '0;
        h_size[i]   <= '0;
        h_cmd[i]    <= '0;
        h_user[i]   <= 1'b0;
      end
    end else begin
      m0_rdvalid   <= 1'b0;
      m1_rdvalid   <= 1'b0;
      mmu_validcmd <= 1'b0;
      // a pulse arriving while its slot is still pending is dropped
      if (m0_valid && !pend[0]) begin
        h_addr[0]   <= m0_addr;
        h_wrdata[0] <= m0_wrdata;
        h_size[0]   <= m0_size;
        h_cmd[0]    <= m0_cmd;
        h_user[0]   <= m0_usermode;
        pend[0]     <= 1'b1;
      end
      if (m1_valid && !pend[1]) begin
        h_addr[1]   <= m1_addr;
        h_wrdata[1] <= m1_wrdata;
        h_size[1]   <= m1_size;
        h_cmd[1]    <= m1_cmd;
        h_user[1]   <= m1_usermode;
        pend[1]     <= 1'b1;
      end
      if (state == IDLE) begin
        if (|pend) begin
          mmu_addr     <= h_addr[gnt];
          mmu_wrdata   <= h_wrdata[gnt];
          mmu_size     <= h_size[gnt];
          mmu_cmd      <= h_cmd[gnt];
          mmu_usermode <= h_user[gnt];
          mmu_validcmd <= 1'b1;
          last_grant   <= gnt;
          owner        <= gnt;
          watchdog     <= '0;
          state        <= WAIT;
        end
      end else begin
        watchdog <= watchdog + 16'd1;
        // a real response takes priority over the watchdog in the same cycle
        if (done) begin
          pend[owner] <= 1'b0;
          state       <= IDLE;
          if (owner) begin
            m1_rdvalid <= 1'b1;
            m1_rddata  <= rsp_data;
            m1_error   <= rsp_err;
          end else begin
            m0_rdvalid <= 1'b1;
            m0_rddata  <= rsp_data;
            m0_error   <= rsp_err;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: directed scenario bench for mmu_arbiter with TIMEOUT=10
module tb_mmu_arbiter;
  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] m0_addr, m0_wrdata, m1_addr, m1_wrdata;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_cmd, m1_cmd;
  logic        m0_valid, m0_usermode, m1_valid, m1_usermode;
  logic [31:0] m0_rddata, m1_rddata;
  logic        m0_rdvalid, m1_rdvalid;
  logic [3:0]  m0_error, m1_error;
  logic [31:0] mmu_addr, mmu_wrdata, mmu_rddata;
  logic [1:0]  mmu_size;
  logic [3:0]  mmu_cmd, mmu_error;
  logic        mmu_validcmd, mmu_usermode, mmu_rddata_valid;
  logic [145:0] all_out;
  int vec = 0;
  int err = 0;

  assign all_out = {m0_rddata, m0_rdvalid, m0_error, m1_rddata, m1_rdvalid, m1_error,
                    mmu_addr, mmu_wrdata, mmu_size, mmu_cmd, mmu_validcmd, mmu_usermode};

  always #5 i_clk = ~i_clk;

  mmu_arbiter #(.TIMEOUT(10), .ERR_TIMEOUT(4'hF)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_size(m0_size), .m0_cmd(m0_cmd),
    .m0_valid(m0_valid), .m0_usermode(m0_usermode),
    .m0_rddata(m0_rddata), .m0_rdvalid(m0_rdvalid), .m0_error(m0_error),
    .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_size(m1_size), .m1_cmd(m1_cmd),
    .m1_valid(m1_valid), .m1_usermode(m1_usermode),
    .m1_rddata(m1_rddata), .m1_rdvalid(m1_rdvalid), .m1_error(m1_error),
    .mmu_addr(mmu_addr), .mmu_wrdata(mmu_wrdata), .mmu_size(mmu_size), .mmu_cmd(mmu_cmd),
    .mmu_validcmd(mmu_validcmd), .mmu_usermode(mmu_usermode),
    .mmu_rddata(mmu_rddata), .mmu_rddata_valid(mmu_rddata_valid), .mmu_error(mmu_error)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // waits for a grant, answers it after lat cycles, and reports what came back
  task automatic serve(input int lat, input logic [31:0] d, input logic [3:0] e,
                       output logic [31:0] a, output logic [1:0] rv,
                       output logic [31:0] rd, output logic [3:0] er, output logic ok);
    for (int i = 0; i < 40 && !mmu_validcmd; i++) tick();
    ok = mmu_validcmd;
    a = mmu_addr;
    repeat (lat) tick();
    mmu_rddata_valid = 1'b1;
    mmu_rddata = d;
    mmu_error = e;
    tick();
    mmu_rddata_valid = 1'b0;
    mmu_rddata = '0;
    mmu_error = '0;
    rv = {m1_rdvalid, m0_rdvalid};
    rd = m1_rdvalid ? m1_rddata : m0_rddata;
    er = m1_rdvalid ? m1_error : m0_error;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    tick();
    tick();
    vec++;
    if (all_out !== '0) begin
      err++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    m0_addr = 32'h1000; m0_size = 2'b11; m0_cmd = 4'h1; m0_valid = 1'b1;
    tick();
    m0_valid = 1'b0;
    vec++;
    if (mmu_validcmd !== 1'b0) begin err++; $display("FAIL read_early_cmd: got %b want 0", mmu_validcmd); end
    tick();
    vec++;
    if ({mmu_validcmd, mmu_addr, mmu_size} !== {1'b1, 32'h1000, 2'b11}) begin
      err++; $display("FAIL read_grant: got %b %h %b want 1 00001000 11", mmu_validcmd, mmu_addr, mmu_size);
    end
    tick();
    vec++;
    if ({mmu_validcmd, mmu_addr} !== {1'b0, 32'h1000}) begin
      err++; $display("FAIL read_hold: got %b %h want 0 00001000", mmu_validcmd, mmu_addr);
    end
    tick();
    tick();
    mmu_rddata_valid = 1'b1; mmu_rddata = 32'hDEADBEEF; mmu_error = 4'h0;
    vec++;
    if (m0_rdvalid !== 1'b0) begin err++; $display("FAIL read_early_rdvalid: got %b want 0", m0_rdvalid); end
    tick();
    mmu_rddata_valid = 1'b0; mmu_rddata = '0;
    vec++;
    if ({m0_rdvalid, m0_rddata, m0_error, m1_rdvalid} !== {1'b1, 32'hDEADBEEF, 4'h0, 1'b0}) begin
      err++; $display("FAIL read_complete: got %b %h %h %b want 1 deadbeef 0 0", m0_rdvalid, m0_rddata, m0_error, m1_rdvalid);
    end
    tick();
    vec++;
    if ({m0_rdvalid, m0_rddata} !== {1'b0, 32'hDEADBEEF}) begin
      err++; $display("FAIL read_pulse_hold: got %b %h want 0 deadbeef", m0_rdvalid, m0_rddata);
    end
  endtask

  task automatic test_contention();
    logic [31:0] a, rd; logic [1:0] rv; logic [3:0] er; logic ok;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0;
    serve(2, 32'hAAAA0000, 4'h0, a, rv, rd, er, ok);
    vec++;
    if ({ok, a, rv, rd} !== {1'b1, 32'h10, 2'b01, 32'hAAAA0000}) begin
      err++; $display("FAIL contention_first: got %b %h %b %h want 1 00000010 01 aaaa0000", ok, a, rv, rd);
    end
    serve(2, 32'hBBBB0000, 4'h0, a, rv, rd, er, ok);
    vec++;
    if ({ok, a, rv, rd} !== {1'b1, 32'h20, 2'b10, 32'hBBBB0000}) begin
      err++; $display("FAIL contention_second: got %b %h %b %h want 1 00000020 10 bbbb0000", ok, a, rv, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, rd; logic [1:0] rv; logic [3:0] er; logic ok;
    m0_addr = 32'h100; m1_addr = 32'h200; m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve(1, 32'h100 + i, 4'h0, a, rv, rd, er, ok);
      vec++;
      if ({ok, rv, a, rd} !== {1'b1, (i % 2 == 1) ? 2'b10 : 2'b01, (i % 2 == 1) ? 32'h200 : 32'h100, 32'h100 + i}) begin
        err++; $display("FAIL fair_order_%0d: got %b %b %h %h want port %0d", i, ok, rv, a, rd, i % 2);
      end
      if (i < 6) begin
        m0_valid = rv[0]; m1_valid = rv[1];
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_write_error();
    logic [31:0] a, rd; logic [1:0] rv; logic [3:0] er; logic ok;
    m1_addr = 32'h2000; m1_wrdata = 32'hCAFEF00D; m1_cmd = 4'h2; m1_size = 2'b10; m1_usermode = 1'b1;
    m1_valid = 1'b1;
    tick();
    m1_valid = 1'b0;
    serve(3, 32'h12345678, 4'h2, a, rv, rd, er, ok);
    vec++;
    if ({ok, a, mmu_wrdata, mmu_cmd, mmu_size, mmu_usermode} !== {1'b1, 32'h2000, 32'hCAFEF00D, 4'h2, 2'b10, 1'b1}) begin
      err++; $display("FAIL write_cmd: got %b %h %h %h %b %b", ok, a, mmu_wrdata, mmu_cmd, mmu_size, mmu_usermode);
    end
    vec++;
    if ({rv, rd, er, m0_rddata} !== {2'b10, 32'h12345678, 4'h2, 32'h106}) begin
      err++; $display("FAIL write_resp: got %b %h %h m0=%h want 10 12345678 2 m0=00000106", rv, rd, er, m0_rddata);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, rd; logic [1:0] rv; logic [3:0] er; logic ok; logic early;
    m0_addr = 32'h3000; m0_valid = 1'b1;
    tick();
    m0_valid = 1'b0;
    tick();
    vec++;
    if (mmu_validcmd !== 1'b1) begin err++; $display("FAIL timeout_grant: got %b want 1", mmu_validcmd); end
    early = 1'b0;
    for (int k = 1; k < 10; k++) begin
      tick();
      early |= m0_rdvalid | m1_rdvalid;
    end
    vec++;
    if (early !== 1'b0) begin err++; $display("FAIL timeout_early: got %b want 0", early); end
    tick();
    vec++;
    if ({m0_rdvalid, m0_rddata, m0_error, m1_rdvalid} !== {1'b1, 32'h0, 4'hF, 1'b0}) begin
      err++; $display("FAIL timeout_complete: got %b %h %h %b want 1 00000000 f 0", m0_rdvalid, m0_rddata, m0_error, m1_rdvalid);
    end
    m1_addr = 32'h3100; m1_valid = 1'b1;
    tick();
    m1_valid = 1'b0;
    serve(1, 32'h31, 4'h0, a, rv, rd, er, ok);
    vec++;
    if ({ok, a, rv, rd} !== {1'b1, 32'h3100, 2'b10, 32'h31}) begin
      err++; $display("FAIL timeout_recover: got %b %h %b %h want 1 00003100 10 00000031", ok, a, rv, rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a, rd; logic [1:0] rv; logic [3:0] er; logic ok; logic dirty;
    m0_addr = 32'h5000; m0_valid = 1'b1;
    tick();
    m0_valid = 1'b0;
    tick();
    vec++;
    if (mmu_validcmd !== 1'b1) begin err++; $display("FAIL rst_wait_grant: got %b want 1", mmu_validcmd); end
    tick();
    tick();
    i_reset_n = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
    mmu_rddata_valid = 1'b1; mmu_rddata = 32'h55; mmu_error = 4'h3;
    tick();
    mmu_rddata_valid = 1'b0; mmu_rddata = '0; mmu_error = '0;
    dirty = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dirty |= (all_out !== '0);
      tick();
    end
    vec++;
    if (dirty !== 1'b0) begin err++; $display("FAIL rst_wait_quiet: got %b want 0 (%h)", dirty, all_out); end
    m1_addr = 32'h4000; m1_valid = 1'b1;
    tick();
    m1_valid = 1'b0;
    serve(2, 32'h77, 4'h0, a, rv, rd, er, ok);
    vec++;
    if ({ok, a, rv, rd, er} !== {1'b1, 32'h4000, 2'b10, 32'h77, 4'h0}) begin
      err++; $display("FAIL rst_wait_next: got %b %h %b %h %h want 1 00004000 10 00000077 0", ok, a, rv, rd, er);
    end
  endtask

  initial begin
    i_reset_n = 1'b0;
    m0_addr = '0; m0_wrdata = '0; m0_size = '0; m0_cmd = '0; m0_valid = 1'b0; m0_usermode = 1'b0;
    m1_addr = '0; m1_wrdata = '0; m1_size = '0; m1_cmd = '0; m1_valid = 1'b0; m1_usermode = 1'b0;
    mmu_rddata = '0; mmu_rddata_valid = 1'b0; mmu_error = '0;
    test_reset();
    test_read();
    test_reset();
    test_contention();
    test_back_to_back();
    test_write_error();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
